// File: rtl/seg7_byte_decoder.sv
// Decodes a stream of active-low 7-segment digits back to nibbles and pairs them into bytes.
// Optional macro SEG7_BLANK_AS_ZERO_EN: the all-off pattern 1111111 decodes as 0.
module seg7_byte_decoder #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [0:6]   seg_i,
  input  logic         seg_valid_i,
  output logic [7:0]   byte_o,
  output logic         byte_valid_o,
  output logic         digit_err_o,
  output logic         timeout_o,
  output logic         busy_o
);

  localparam logic [0:0] StWaitLo = 1'b0;
  localparam logic [0:0] StWaitHi = 1'b1;

  localparam bit TimeoutEn = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CntLast = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [3:0]       lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             digit_err_q, digit_err_d;
  logic             timeout_q, timeout_d;

  logic [3:0] nib;
  logic       nib_ok;

  // Leftmost literal bit is seg_i[0] (segment a).
  always_comb begin
    nib    = 4'h0;
    nib_ok = 1'b1;
    case (seg_i)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
`ifdef SEG7_BLANK_AS_ZERO_EN
      7'b1111111: nib = 4'h0;
`endif
      default:    nib_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    digit_err_d  = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      StWaitLo: begin
        if (seg_valid_i) begin
          if (nib_ok) begin
            lo_d    = nib;
            cnt_d   = '0;
            state_d = StWaitHi;
          end else begin
            digit_err_d = 1'b1;
          end
        end
      end
      StWaitHi: begin
        // A strobe on the timeout cycle takes priority over the timeout.
        if (seg_valid_i) begin
          state_d = StWaitLo;
          lo_d    = 4'h0;
          cnt_d   = '0;
          if (nib_ok) begin
            byte_d       = {nib, lo_q};
            byte_valid_d = 1'b1;
          end else begin
            digit_err_d = 1'b1;
          end
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          timeout_d = 1'b1;
          state_d   = StWaitLo;
          lo_d      = 4'h0;
          cnt_d     = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StWaitLo;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StWaitLo;
      lo_q         <= 4'h0;
      cnt_q        <= '0;
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      digit_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      digit_err_q  <= digit_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign digit_err_o  = digit_err_q;
  assign timeout_o    = timeout_q;
  assign busy_o       = (state_q == StWaitHi);

endmodule

// File: tb/tb_seg7_byte_decoder.sv
// Directed scoreboard bench for seg7_byte_decoder with TIMEOUT=4.
module tb_seg7_byte_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [0:6] seg_i = 7'b0;
  logic       seg_valid_i = 1'b0;
  logic [7:0] byte_o;
  logic       byte_valid_o, digit_err_o, timeout_o, busy_o;

  seg7_byte_decoder #(
    .TIMEOUT(4),
    .CNT_W  (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .seg_i       (seg_i),
    .seg_valid_i (seg_valid_i),
    .byte_o      (byte_o),
    .byte_valid_o(byte_valid_o),
    .digit_err_o (digit_err_o),
    .timeout_o   (timeout_o),
    .busy_o      (busy_o)
  );

  always #5 clock = ~clock;

  // {byte, byte_valid, digit_err, timeout, busy}
  typedef logic [11:0] exp_t;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100;
  localparam logic [6:0] P7 = 7'b0001111, P8 = 7'b0000000, P9 = 7'b0000100;
  localparam logic [6:0] PA = 7'b0001000, PC = 7'b0110001, PF = 7'b0111000;
  localparam logic [6:0] PBAD = 7'b1010101, PBAD2 = 7'b1111110, PBLANK = 7'b1111111;

  function automatic exp_t observed();
    return {byte_o, byte_valid_o, digit_err_o, timeout_o, busy_o};
  endfunction

  task automatic check(input string tag, input exp_t obs, input exp_t want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: got byte=%h bv=%b err=%b to=%b busy=%b, want byte=%h bv=%b err=%b to=%b busy=%b",
             tag, obs[11:4], obs[3], obs[2], obs[1], obs[0],
             want[11:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  // Drive one cycle (called at a negedge) and check the registered result at the next negedge.
  task automatic step(input string tag, input logic v, input logic [6:0] s, input logic [7:0] eb,
                      input logic ebv, input logic eerr, input logic eto, input logic ebusy);
    seg_valid_i = v;
    seg_i       = s;
    exp_q.push_back({eb, ebv, eerr, eto, ebusy});
    @(negedge clock);
    check(tag, observed(), exp_q.pop_front());
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    check("reset", observed(), 12'h000);
    reset = 1'b1;
    step("idle0", 1'b0, 7'h00, 8'h00, 0, 0, 0, 0);

    // 5 then 7 with a gap: busy between strobes
    step("lo5",   1'b1, P5, 8'h00, 0, 0, 0, 1);
    step("gap",   1'b0, 7'h00, 8'h00, 0, 0, 0, 1);
    step("hi7",   1'b1, P7, 8'h75, 1, 0, 0, 0);
    step("hold1", 1'b0, 7'h00, 8'h75, 0, 0, 0, 0);

    // Back-to-back pairs
    step("loF",   1'b1, PF, 8'h75, 0, 0, 0, 1);
    step("hiC",   1'b1, PC, 8'hCF, 1, 0, 0, 0);
    step("lo0",   1'b1, P0, 8'hCF, 0, 0, 0, 1);
    step("hi1",   1'b1, P1, 8'h10, 1, 0, 0, 0);
    step("hold2", 1'b0, 7'h00, 8'h10, 0, 0, 0, 0);

    // Invalid high digit, then invalid low digit
    step("lo3",   1'b1, P3, 8'h10, 0, 0, 0, 1);
    step("hibad", 1'b1, PBAD, 8'h10, 0, 1, 0, 0);
    step("hold3", 1'b0, 7'h00, 8'h10, 0, 0, 0, 0);
    step("lobad", 1'b1, PBAD2, 8'h10, 0, 1, 0, 0);
    step("lo9",   1'b1, P9, 8'h10, 0, 0, 0, 1);
    step("hi0",   1'b1, P0, 8'h09, 1, 0, 0, 0);

    // Timeout after 4 idle cycles
    step("lo2a",  1'b1, P2, 8'h09, 0, 0, 0, 1);
    step("idle1", 1'b0, 7'h00, 8'h09, 0, 0, 0, 1);
    step("idle2", 1'b0, 7'h00, 8'h09, 0, 0, 0, 1);
    step("idle3", 1'b0, 7'h00, 8'h09, 0, 0, 0, 1);
    step("tmo",   1'b0, 7'h00, 8'h09, 0, 0, 1, 0);
    step("tmo_end", 1'b0, 7'h00, 8'h09, 0, 0, 0, 0);

    // High digit on the exact timeout cycle wins
    step("lo2b",  1'b1, P2, 8'h09, 0, 0, 0, 1);
    step("wait1", 1'b0, 7'h00, 8'h09, 0, 0, 0, 1);
    step("wait2", 1'b0, 7'h00, 8'h09, 0, 0, 0, 1);
    step("wait3", 1'b0, 7'h00, 8'h09, 0, 0, 0, 1);
    step("race",  1'b1, P1, 8'h12, 1, 0, 0, 0);
    step("hold4", 1'b0, 7'h00, 8'h12, 0, 0, 0, 0);

    // Asynchronous reset mid-pair
    step("loA",   1'b1, PA, 8'h12, 0, 0, 0, 1);
    seg_valid_i = 1'b0;
    #2 reset = 1'b0;
    #1 check("async_rst", observed(), 12'h000);
    @(negedge clock);
    reset = 1'b1;
    step("lo8",   1'b1, P8, 8'h00, 0, 0, 0, 1);
    step("hi1b",  1'b1, P1, 8'h18, 1, 0, 0, 0);

    // Blank pattern as high digit
    step("lo4",   1'b1, P4, 8'h18, 0, 0, 0, 1);
`ifdef SEG7_BLANK_AS_ZERO_EN
    step("blank", 1'b1, PBLANK, 8'h04, 1, 0, 0, 0);
    step("hold5", 1'b0, 7'h00, 8'h04, 0, 0, 0, 0);
`else
    step("blank", 1'b1, PBLANK, 8'h18, 0, 1, 0, 0);
    step("hold5", 1'b0, 7'h00, 8'h18, 0, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
